// File: rtl/alu_issue_sched.sv
// rtl/alu_issue_sched.sv - integer ALU issue scheduler with oldest-ready select
//
// Purpose:
//   Holds dispatched integer uops until both source operands are ready. Each
//   cycle it selects the oldest ready entry by sequence number and loads it
//   into a registered issue stage that feeds the single ALU port. The issue
//   register holds under writeback stall. A branch-mispredict flush removes
//   every uop younger than a given sequence number.
//
// Optional feature:
//   ALU_SCHED_PERF_EN - when defined, adds the OUT_perfIssued and
//   OUT_perfStallCycles 32-bit wrapping counters.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   IN_enq*                   dispatch offer: sqN, source tags/ready bits, payload
//   OUT_enqReady              a free slot exists (registered count < DEPTH)
//   IN_wakeValid/Tag          writeback-bus wakeup
//   IN_zcFwdValid/Tag         ALU zero-cycle forward wakeup
//   IN_wbStall                hold the issue register; no select this cycle
//   IN_invalidate/SqN         flush uops younger than IN_invalidateSqN
//   OUT_issueValid/SqN/Payload  issue register contents
//   OUT_count                 number of occupied entries
//   OUT_perfIssued            (ALU_SCHED_PERF_EN) valid uops loaded into issue
//   OUT_perfStallCycles       (ALU_SCHED_PERF_EN) cycles stalled with a valid issue

module alu_issue_sched #(
    parameter int DEPTH     = 8,
    parameter int TAG_W     = 7,
    parameter int SQN_W     = 7,
    parameter int PAYLOAD_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    IN_enqValid,
    input  logic [SQN_W-1:0]        IN_enqSqN,
    input  logic [TAG_W-1:0]        IN_enqTagA,
    input  logic                    IN_enqRdyA,
    input  logic [TAG_W-1:0]        IN_enqTagB,
    input  logic                    IN_enqRdyB,
    input  logic [PAYLOAD_W-1:0]    IN_enqPayload,
    output logic                    OUT_enqReady,
    input  logic                    IN_wakeValid,
    input  logic [TAG_W-1:0]        IN_wakeTag,
    input  logic                    IN_zcFwdValid,
    input  logic [TAG_W-1:0]        IN_zcFwdTag,
    input  logic                    IN_wbStall,
    input  logic                    IN_invalidate,
    input  logic [SQN_W-1:0]        IN_invalidateSqN,
    output logic                    OUT_issueValid,
    output logic [SQN_W-1:0]        OUT_issueSqN,
    output logic [PAYLOAD_W-1:0]    OUT_issuePayload,
    output logic [$clog2(DEPTH):0]  OUT_count
`ifdef ALU_SCHED_PERF_EN
    ,
    output logic [31:0]             OUT_perfIssued,
    output logic [31:0]             OUT_perfStallCycles
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // a is younger than b: the wrapped difference is strictly positive.
    function automatic logic sqn_younger(input logic [SQN_W-1:0] a,
                                         input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] d;
        d = a - b;
        return (d != '0) && !d[SQN_W-1];
    endfunction

    // a is older than b: the wrapped difference is negative.
    function automatic logic sqn_older(input logic [SQN_W-1:0] a,
                                       input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] d;
        d = a - b;
        return d[SQN_W-1];
    endfunction

    // Tag 0 is the hardwired zero register and must never be woken by a bus.
    function automatic logic tag_wakes(input logic [TAG_W-1:0] tag,
                                       input logic             wv,
                                       input logic [TAG_W-1:0] wt,
                                       input logic             zv,
                                       input logic [TAG_W-1:0] zt);
        return (tag != '0) && ((wv && (tag == wt)) || (zv && (tag == zt)));
    endfunction

    // Entry storage
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     rdy_a_q, rdy_a_d;
    logic [DEPTH-1:0]     rdy_b_q, rdy_b_d;
    logic [SQN_W-1:0]     sqn_q     [DEPTH];
    logic [SQN_W-1:0]     sqn_d     [DEPTH];
    logic [TAG_W-1:0]     tag_a_q   [DEPTH];
    logic [TAG_W-1:0]     tag_a_d   [DEPTH];
    logic [TAG_W-1:0]     tag_b_q   [DEPTH];
    logic [TAG_W-1:0]     tag_b_d   [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];

    logic [CNT_W-1:0]     count_q, count_d;

    // Issue register
    logic                 issue_valid_q, issue_valid_d;
    logic [SQN_W-1:0]     issue_sqn_q, issue_sqn_d;
    logic [PAYLOAD_W-1:0] issue_payload_q, issue_payload_d;

    // Select / allocate
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     free_idx;
    logic                 enq_accept;

    assign OUT_enqReady     = (count_q < CNT_W'(DEPTH));
    assign OUT_count        = count_q;
    assign OUT_issueValid   = issue_valid_q;
    assign OUT_issueSqN     = issue_sqn_q;
    assign OUT_issuePayload = issue_payload_q;

    // Oldest ready entry. Only registered ready bits are used, so a wakeup
    // seen this cycle becomes selectable one cycle later.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rdy_a_q[i] && rdy_b_q[i]) begin
                if (!sel_found || sqn_older(sqn_q[i], sqn_q[sel_idx])) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Lowest-index free slot; scanning downward leaves the lowest one last.
    // Only meaningful when OUT_enqReady is high.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        valid_d         = valid_q;
        rdy_a_d         = rdy_a_q;
        rdy_b_d         = rdy_b_q;
        sqn_d           = sqn_q;
        tag_a_d         = tag_a_q;
        tag_b_d         = tag_b_q;
        payload_d       = payload_q;
        issue_valid_d   = issue_valid_q;
        issue_sqn_d     = issue_sqn_q;
        issue_payload_d = issue_payload_q;
        count_d         = '0;

        enq_accept = IN_enqValid && OUT_enqReady &&
                     !(IN_invalidate && sqn_younger(IN_enqSqN, IN_invalidateSqN));

        // Wakeup of resident entries
        for (int i = 0; i < DEPTH; i++) begin
            if (tag_wakes(tag_a_q[i], IN_wakeValid, IN_wakeTag, IN_zcFwdValid, IN_zcFwdTag)) begin
                rdy_a_d[i] = 1'b1;
            end
            if (tag_wakes(tag_b_q[i], IN_wakeValid, IN_wakeTag, IN_zcFwdValid, IN_zcFwdTag)) begin
                rdy_b_d[i] = 1'b1;
            end
        end

        // A flush reaches into the issue register even while it is stalled.
        if (IN_invalidate && issue_valid_q && sqn_younger(issue_sqn_q, IN_invalidateSqN)) begin
            issue_valid_d = 1'b0;
        end

        if (!IN_wbStall) begin
            issue_valid_d = 1'b0;
            if (sel_found) begin
                valid_d[sel_idx] = 1'b0;
                // A selected uop that is being flushed is freed but not issued.
                if (!(IN_invalidate && sqn_younger(sqn_q[sel_idx], IN_invalidateSqN))) begin
                    issue_valid_d   = 1'b1;
                    issue_sqn_d     = sqn_q[sel_idx];
                    issue_payload_d = payload_q[sel_idx];
                end
            end
        end

        if (IN_invalidate) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && sqn_younger(sqn_q[i], IN_invalidateSqN)) begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        // The incoming uop also snoops this cycle's wakeup buses.
        if (enq_accept) begin
            valid_d[free_idx]   = 1'b1;
            sqn_d[free_idx]     = IN_enqSqN;
            tag_a_d[free_idx]   = IN_enqTagA;
            tag_b_d[free_idx]   = IN_enqTagB;
            payload_d[free_idx] = IN_enqPayload;
            rdy_a_d[free_idx]   = IN_enqRdyA ||
                tag_wakes(IN_enqTagA, IN_wakeValid, IN_wakeTag, IN_zcFwdValid, IN_zcFwdTag);
            rdy_b_d[free_idx]   = IN_enqRdyB ||
                tag_wakes(IN_enqTagB, IN_wakeValid, IN_wakeTag, IN_zcFwdValid, IN_zcFwdTag);
        end

        // Occupancy is recomputed from the next valid vector, which folds in
        // enqueue, issue and flush in one place.
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q       <= '0;
            rdy_a_q       <= '0;
            rdy_b_q       <= '0;
            count_q       <= '0;
            issue_valid_q <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            rdy_a_q       <= rdy_a_d;
            rdy_b_q       <= rdy_b_d;
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
        end
    end

    // Data fields are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        sqn_q           <= sqn_d;
        tag_a_q         <= tag_a_d;
        tag_b_q         <= tag_b_d;
        payload_q       <= payload_d;
        issue_sqn_q     <= issue_sqn_d;
        issue_payload_q <= issue_payload_d;
    end

`ifdef ALU_SCHED_PERF_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_stall_q;

    // When not stalled, issue_valid_d is high exactly when a uop is loaded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (!IN_wbStall && issue_valid_d) begin
                perf_issued_q <= perf_issued_q + 32'd1;
            end
            if (IN_wbStall && issue_valid_q) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign OUT_perfIssued      = perf_issued_q;
    assign OUT_perfStallCycles = perf_stall_q;
`endif

endmodule

// File: doc/alu_issue_sched.md
Name: alu_issue_sched

Overview:
- Issue scheduler that owns the single integer ALU port.
- Buffers dispatched integer uops until both source operands are ready, then selects the oldest ready entry (by sqN) each cycle.
- Drives it through a registered issue stage into the ALU.
- Honours writeback stall backpressure and branch-mispredict invalidation by sqN.

Parameters:
- DEPTH, 8, number of scheduler entries (power of two, 2..16)
- TAG_W, 7, physical register tag width
- SQN_W, 7, sequence number width (wraps; ordering by signed difference)
- PAYLOAD_W, 64, opaque uop payload forwarded to the ALU unchanged

Ports:
- clk in 1 system clock
- rst in 1 reset, synchronous, active-low
- IN_enqValid in 1 dispatch offers a uop this cycle
- IN_enqSqN in SQN_W sequence number of offered uop
- IN_enqTagA in TAG_W source A tag
- IN_enqRdyA in 1 source A already available at dispatch
- IN_enqTagB in TAG_W source B tag
- IN_enqRdyB in 1 source B already available at dispatch
- IN_enqPayload in PAYLOAD_W uop payload
- OUT_enqReady out 1 scheduler can accept a uop this cycle
- IN_wakeValid in 1 writeback-bus result valid
- IN_wakeTag in TAG_W writeback-bus result tag
- IN_zcFwdValid in 1 ALU zero-cycle forward valid
- IN_zcFwdTag in TAG_W ALU zero-cycle forward tag
- IN_wbStall in 1 ALU writeback stalled; issue register must hold
- IN_invalidate in 1 flush uops younger than IN_invalidateSqN
- IN_invalidateSqN in SQN_W flush boundary (entries with sqN <= this survive)
- OUT_issueValid out 1 issue register holds a valid uop
- OUT_issueSqN out SQN_W sqN of issued uop
- OUT_issuePayload out PAYLOAD_W payload of issued uop
- OUT_count out $clog2(DEPTH)+1 occupied entries

Behaviour:
Reset (rst==0 at posedge):
- All entries invalid; OUT_issueValid=0; OUT_count=0.
- OUT_issueSqN and OUT_issuePayload: don't-care.
- OUT_enqReady=1 in the first cycle after reset.
- Reset mid-operation discards all entries and the issue register.

Entry state: valid, sqN, tagA/rdyA, tagB/rdyB, payload.

Enqueue:
- OUT_enqReady = (count < DEPTH), combinational from registered count.
- On IN_enqValid && OUT_enqReady, the uop is written into the lowest-index free slot at the posedge.
- IN_enqValid while not ready is ignored; dispatch must hold the uop.

Wakeup:
- Any valid entry whose tagA/tagB equals a valid IN_wakeTag or IN_zcFwdTag sets rdyA/rdyB.
- The uop being enqueued in the same cycle is also compared; a match sets its rdy bit at write.
- Tag 0 never wakes (zero register); enqueue marks it via IN_enqRdyX.

Select:
- Candidates: valid entries with rdyA&&rdyB.
- Pick the oldest, i.e. the minimal sqN under signed (sqN_i - sqN_j) comparison.
- Ties are impossible (unique sqN).
- Wakeup takes effect next cycle: an entry woken at edge N is selectable for the edge N+1 issue.
- Minimum dispatch-to-issue latency: enqueued at edge N with both rdy, OUT_issueValid at edge N+1.

Issue register:
- When !IN_wbStall, load the selected entry (or clear OUT_issueValid if no candidate) and free that entry in the same edge.
- When IN_wbStall, hold all issue outputs and perform no select. Enqueue and wakeup still proceed.

Invalidate (IN_invalidate=1):
- Every entry with signed(sqN - IN_invalidateSqN) > 0 is cleared.
- The issue register is cleared if its sqN is younger, regardless of IN_wbStall.
- An entry selected this cycle that is younger is not issued.
- An enqueue offered this cycle that is younger is dropped.
- Older/equal uops proceed normally.

Count:
- count_next = count + enq_accepted - issued - invalidated_entries.
- Saturation is impossible by construction.
- Full (count==DEPTH): OUT_enqReady=0. An issue in the same cycle frees a slot only for the next cycle (no bypass).

Wrap-around: sqN comparisons always use the SQN_W-bit signed difference; correct across 2^SQN_W wrap provided the in-flight window is < 2^(SQN_W-1).

Optional Feature:
- Macro ALU_SCHED_PERF_EN.
- Defined: adds outputs OUT_perfIssued (32) and OUT_perfStallCycles (32).
  - OUT_perfIssued increments on each load of a valid uop into the issue register.
  - OUT_perfStallCycles increments on each cycle with IN_wbStall && OUT_issueValid.
  - Both wrap, reset to 0, and are unaffected by invalidate.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then enqueue sqN=5 with rdyA=rdyB=1 at edge 1 -> OUT_issueValid=1, OUT_issueSqN=5 after edge 2; OUT_count 0->1->0.
- Enqueue sqN=10 (tagA=12 not ready) then sqN=11 (ready) -> sqN=11 issues first; IN_wakeTag=12 pulse -> sqN=10 issues the following cycle.
- Fill 8 ready entries with IN_wbStall=1 -> OUT_enqReady=0, OUT_count=8, issue outputs frozen; release stall -> issue order is ascending sqN, one per cycle.
- Entries sqN=126,127,0,1 all ready (SQN_W=7 wrap) -> issue order 126,127,0,1.
- Entries sqN=20..23, issue register holds 22 under stall; IN_invalidate with IN_invalidateSqN=21 plus concurrent enqueue sqN=24 -> 22,23,24 discarded, OUT_issueValid=0, OUT_count=2, then 20,21 issue.
- Enqueue with tagB=9 while IN_zcFwdValid=1, IN_zcFwdTag=9 in the same cycle -> entry issues on the next edge; tag 0 forward never wakes an entry.
